// File: rtl/uart_viterbi_pkg.sv
// Shared types and constants for the UART <-> Viterbi decoder sequencer.
package uart_viterbi_pkg;

    localparam int         SYMS_PER_BYTE = 4;
    localparam logic [2:0] K_MIN         = 3'd3;
    localparam logic [2:0] K_MAX         = 3'd6;
    localparam int         TX_BUSY_GUARD = 4;

    typedef enum logic [1:0] {
        F_IDLE,
        F_LOAD,
        F_FEED
    } feed_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_PULSE,
        T_WAIT_HI,
        T_WAIT_LO
    } tx_state_t;

    function automatic logic k_legal(input logic [2:0] k);
        return (k >= K_MIN) && (k <= K_MAX);
    endfunction

endpackage

// File: rtl/uart_viterbi_ctrl_fifo.sv
// Synchronous byte FIFO (module byte_fifo); push while full is accepted only with a same-cycle pop.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_viterbi_ctrl.sv
// Sequencer: RX bytes -> 2-bit symbols to the Viterbi decoder, decoded bytes -> UART transmitter.
// Optional UART_VITERBI_STATS_EN adds saturating RX-accepted / TX-issued counters.
module uart_viterbi_ctrl
    import uart_viterbi_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] K_DEFAULT  = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [2:0]  cfg_k,
    output logic [2:0]  dec_k,
    output logic [1:0]  dec_sym,
    output logic        dec_sym_valid,
    input  logic        dec_ready,
    input  logic [7:0]  dec_byte,
    input  logic        dec_byte_valid,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        rx_overflow,
    output logic        tx_overflow,
    output logic        cfg_err,
    output logic        busy
`ifdef UART_VITERBI_STATS_EN
    ,
    output logic [15:0] stat_rx_cnt,
    output logic [15:0] stat_tx_cnt
`endif
);

    localparam int                 SYM_CNT_W  = $clog2(SYMS_PER_BYTE);
    localparam logic [SYM_CNT_W-1:0] SYM_LAST = SYM_CNT_W'(SYMS_PER_BYTE - 1);
    localparam int                 GUARD_W    = $clog2(TX_BUSY_GUARD);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(TX_BUSY_GUARD - 1);

    logic       rx_pop, rx_empty, rx_full;
    logic       tx_pop, tx_empty, tx_full;
    logic [7:0] rx_head, tx_head;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_valid),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (dec_byte_valid),
        .wdata_i (dec_byte),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    feed_state_t            feed_q, feed_d;
    logic [7:0]             sh_q, sh_d;
    logic [SYM_CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
    tx_state_t              txs_q, txs_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [GUARD_W-1:0]     guard_q, guard_d;
    logic [2:0]             dec_k_q, dec_k_d;
    logic                   rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, cfg_err_q, cfg_err_d;
    logic                   idle;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        feed_d    = feed_q;
        sh_d      = sh_q;
        sym_cnt_d = sym_cnt_q;
        rx_pop    = 1'b0;
        case (feed_q)
            F_IDLE: if (!rx_empty) feed_d = F_LOAD;
            F_LOAD: begin
                rx_pop    = 1'b1;
                sh_d      = rx_head;
                sym_cnt_d = '0;
                feed_d    = F_FEED;
            end
            F_FEED: if (dec_ready) begin
                sh_d      = {sh_q[5:0], 2'b00};
                sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
                if (sym_cnt_q == SYM_LAST) feed_d = F_IDLE;
            end
            default: feed_d = F_IDLE;
        endcase
    end

    always_comb begin
        txs_d     = txs_q;
        tx_data_d = tx_data_q;
        guard_d   = guard_q;
        tx_pop    = 1'b0;
        case (txs_q)
            T_IDLE: if (!tx_empty && !tx_busy) begin
                tx_pop    = 1'b1;
                tx_data_d = tx_head;
                txs_d     = T_PULSE;
            end
            T_PULSE: begin
                guard_d = '0;
                txs_d   = T_WAIT_HI;
            end
            // Give up on a transmitter that never raises busy rather than stall forever.
            T_WAIT_HI: begin
                if (tx_busy)                  txs_d   = T_WAIT_LO;
                else if (guard_q == GUARD_LAST) txs_d = T_IDLE;
                else                          guard_d = guard_q + GUARD_W'(1);
            end
            T_WAIT_LO: if (!tx_busy) txs_d = T_IDLE;
            default:   txs_d = T_IDLE;
        endcase
    end

    assign idle = (feed_q == F_IDLE) && (txs_q == T_IDLE) && rx_empty && tx_empty;

    always_comb begin
        dec_k_d   = dec_k_q;
        cfg_err_d = cfg_err_q;
        rx_ovf_d  = rx_ovf_q  | (rx_valid && rx_full && !rx_pop);
        tx_ovf_d  = tx_ovf_q  | (dec_byte_valid && tx_full && !tx_pop);
        if (idle) begin
            if (k_legal(cfg_k)) dec_k_d   = cfg_k;
            else                cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            feed_q    <= F_IDLE;
            sh_q      <= '0;
            sym_cnt_q <= '0;
            txs_q     <= T_IDLE;
            tx_data_q <= '0;
            guard_q   <= '0;
            dec_k_q   <= K_DEFAULT;
            rx_ovf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            feed_q    <= feed_d;
            sh_q      <= sh_d;
            sym_cnt_q <= sym_cnt_d;
            txs_q     <= txs_d;
            tx_data_q <= tx_data_d;
            guard_q   <= guard_d;
            dec_k_q   <= dec_k_d;
            rx_ovf_q  <= rx_ovf_d;
            tx_ovf_q  <= tx_ovf_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign dec_k         = dec_k_q;
    assign dec_sym_valid = (feed_q == F_FEED);
    assign dec_sym       = dec_sym_valid ? sh_q[7:6] : 2'b00;
    // Masked by rst so a pulse pending at reset never reaches the transmitter.
    assign tx_start      = (txs_q == T_PULSE) && !rst;
    assign tx_data       = tx_data_q;
    assign rx_overflow   = rx_ovf_q;
    assign tx_overflow   = tx_ovf_q;
    assign cfg_err       = cfg_err_q;
    assign busy          = !idle;

`ifdef UART_VITERBI_STATS_EN
    logic [15:0] stat_rx_q, stat_tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rx_q <= '0;
            stat_tx_q <= '0;
        end else begin
            if (rx_valid && (!rx_full || rx_pop) && stat_rx_q != 16'hFFFF)
                stat_rx_q <= stat_rx_q + 16'd1;
            if (txs_q == T_PULSE && stat_tx_q != 16'hFFFF)
                stat_tx_q <= stat_tx_q + 16'd1;
        end
    end

    assign stat_rx_cnt = stat_rx_q;
    assign stat_tx_cnt = stat_tx_q;
`endif

endmodule
